// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC and selects the next PC from
// sequential, branch, JAL, JALR and trap-redirect sources, with a RUN/HALT FSM.
module pc_unit #(
    parameter int unsigned            PC_WIDTH     = 32,
    parameter int unsigned            IMM_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter int unsigned            INST_BYTES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  ALU_zero,
    input  logic                  jump,
    input  logic                  jalr,
    input  logic [IMM_WIDTH-1:0]  imm_gen_out,
    input  logic [PC_WIDTH-1:0]   rs1_val,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic [PC_WIDTH-1:0]   pc_plus_inst,
    output logic                  taken,
    output logic                  misaligned_fault,
    output logic                  halted
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INST_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] INST_INC   = PC_WIDTH'(INST_BYTES);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                taken_q, taken_d;
    logic                fault_q, fault_d;

    logic [PC_WIDTH-1:0] imm_w;
    logic [PC_WIDTH-1:0] rel_tgt;
    logic [PC_WIDTH-1:0] jalr_tgt;
    logic [PC_WIDTH-1:0] redir_tgt;
    logic [PC_WIDTH-1:0] ctl_tgt;
    logic                ctl_sel;

    assign imm_w     = imm_gen_out[PC_WIDTH-1:0];
    assign rel_tgt   = pc_q + imm_w;
    assign jalr_tgt  = (rs1_val + imm_w) & ~PC_WIDTH'(1);
    assign redir_tgt = redirect_pc & ~ALIGN_MASK;

    // Upper immediate bits are architecturally irrelevant to the PC datapath.
    generate
        if (IMM_WIDTH > PC_WIDTH) begin : g_imm_hi
            logic unused_imm_hi;
            assign unused_imm_hi = ^imm_gen_out[IMM_WIDTH-1:PC_WIDTH];
        end
    endgenerate

    always_comb begin
        ctl_sel = 1'b1;
        ctl_tgt = rel_tgt;
        if (jalr)                      ctl_tgt = jalr_tgt;
        else if (jump)                 ctl_tgt = rel_tgt;
        else if (branch && ALU_zero)   ctl_tgt = rel_tgt;
        else                           ctl_sel = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        fault_d = fault_q;
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    taken_d = 1'b1;
                end else if (!stall) begin
                    if (!ctl_sel) begin
                        pc_d    = pc_q + INST_INC;
                        taken_d = 1'b0;
                    end else if ((ctl_tgt & ALIGN_MASK) != '0) begin
                        // Bad target is dropped; PC stays on the faulting instruction.
                        fault_d = 1'b1;
                        taken_d = 1'b0;
                        state_d = HALT;
                    end else begin
                        pc_d    = ctl_tgt;
                        taken_d = 1'b1;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    taken_d = 1'b1;
                    fault_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            taken_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            fault_q <= fault_d;
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus_inst     = pc_q + INST_INC;
    assign taken            = taken_q;
    assign misaligned_fault = fault_q;
    assign halted           = (state_q == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit; each record is one clock of stimulus
// followed by the expected registered outputs.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, ALU_zero, jump, jalr, redirect_valid;
    logic [63:0] imm_gen_out;
    logic [31:0] rs1_val, redirect_pc;
    logic [31:0] pc_out, pc_plus_inst;
    logic        taken, misaligned_fault, halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .ALU_zero(ALU_zero),
        .jump(jump), .jalr(jalr), .imm_gen_out(imm_gen_out), .rs1_val(rs1_val),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_out(pc_out), .pc_plus_inst(pc_plus_inst), .taken(taken),
        .misaligned_fault(misaligned_fault), .halted(halted)
    );

    typedef struct {
        logic        rst, stl, br, zero, jmp, jr, rv;
        logic [63:0] imm;
        logic [31:0] rs1, rpc;
        logic [31:0] e_pc;
        logic        e_tk, e_f, e_h;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, stl, br, zero, jmp, jr, rv,
                                input logic [63:0] imm, input logic [31:0] rs1, rpc, e_pc,
                                input logic e_tk, e_f, e_h);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.zero = zero; v.jmp = jmp; v.jr = jr; v.rv = rv;
        v.imm = imm; v.rs1 = rs1; v.rpc = rpc;
        v.e_pc = e_pc; v.e_tk = e_tk; v.e_f = e_f; v.e_h = e_h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        reset = v.rst; stall = v.stl; branch = v.br; ALU_zero = v.zero;
        jump = v.jmp; jalr = v.jr; redirect_valid = v.rv;
        imm_gen_out = v.imm; rs1_val = v.rs1; redirect_pc = v.rpc;
        @(posedge clk);
        #1;
        chk({tag, ".pc"},     pc_out,                    v.e_pc);
        chk({tag, ".plus"},   pc_plus_inst,              v.e_pc + 32'd4);
        chk({tag, ".taken"},  {31'd0, taken},            {31'd0, v.e_tk});
        chk({tag, ".fault"},  {31'd0, misaligned_fault}, {31'd0, v.e_f});
        chk({tag, ".halted"}, {31'd0, halted},           {31'd0, v.e_h});
    endtask

    initial begin
        //                 rst stl br z  jmp jr rv  imm                     rs1        rpc            e_pc           tk f  h
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 64'h0,                  32'h0,   32'h0,         32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  32'h0,   32'h0,         32'h4,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  32'h0,   32'h0,         32'h8,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  32'h0,   32'h0,         32'hC,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'h10,        32'h10,        1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 64'h8,                  32'h0,   32'h0,         32'h18,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'h10,        32'h10,        1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 64'h8,                  32'h0,   32'h0,         32'h14,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'h20,        32'h20,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 64'h2,                  32'h101, 32'h0,         32'h20,        0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 64'h4,                  32'h0,   32'h0,         32'h20,        0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 64'h8,                  32'h0,   32'h0,         32'h20,        0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'h200,       32'h200,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0,                  32'h0,   32'h0,         32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'h10,        32'h10,        1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 32'h0,   32'h0,         32'h8,         1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 64'h10,                 32'h0,   32'h0,         32'h18,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 64'h4,                  32'h100, 32'h0,         32'h104,       1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 64'h40,                 32'h0,   32'h300,       32'h300,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 64'h1,                  32'h40,  32'h0,         32'h40,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 64'h6,                  32'h0,   32'h0,         32'h40,        0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 64'h0,                  32'h0,   32'h500,       32'h0,         0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

        // Stall holds PC across several cycles with a pending jump.
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 0, 0, 1, 0, 0, 64'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0), $sformatf("stall%0d", i));
        // A misaligned jump under stall must not fault.
        step(mk(0, 1, 0, 0, 1, 0, 0, 64'h2, 32'h0, 32'h0, 32'h0, 0, 0, 0), "stall_mis");
        step(mk(0, 1, 0, 0, 1, 0, 1, 64'h40, 32'h0, 32'h80, 32'h80, 1, 0, 0), "stall_redir");
        // Taken flag holds under stall after a redirect.
        step(mk(0, 1, 0, 0, 0, 0, 0, 64'h0, 32'h0, 32'h0, 32'h80, 1, 0, 0), "stall_hold_tk");
        step(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 32'h0, 32'h0, 32'h84, 0, 0, 0), "resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
